// File: rtl/phy_pkg.sv
// Shared defaults and types for the PHY buffer SRAM arbiter.
package phy_pkg;

  localparam int PHY_AW        = 7;
  localparam int PHY_DW        = 12;
  localparam int PHY_MAX_BURST = 8;
  localparam int BCNT_W        = 4;  // holds MAX_BURST values up to 15

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [PHY_AW-1:0] addr;
    logic [PHY_DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_burst_picker.sv
// Round-robin owner selection with bounded bursts; grants are combinational
// from the registered owner/beat count and the live request lines.
module rr_burst_picker
  import phy_pkg::*;
#(
  parameter int MAX_BURST = PHY_MAX_BURST
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  localparam logic [BCNT_W-1:0] MAX_CNT = BCNT_W'(MAX_BURST);

  arb_state_t        state, state_nxt;
  logic [BCNT_W-1:0] count, count_nxt;
  logic [BCNT_W-1:0] eff;  // ordinal of this cycle's beat within the owner's burst
  logic              last_owner, last_owner_nxt;
  logic              gv, gp, other_req;

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    gv  = 1'b0;
    gp  = 1'b0;
    eff = BCNT_W'(1);
    case (state)
      OWN0: begin
        if (req0) begin
          gv  = 1'b1;
          eff = count;
        end else if (req1) begin
          gv = 1'b1;
          gp = 1'b1;
        end
      end
      OWN1: begin
        if (req1) begin
          gv  = 1'b1;
          gp  = 1'b1;
          eff = count;
        end else if (req0) begin
          gv = 1'b1;
        end
      end
      default: begin
        gv = req0 | req1;
        gp = (req0 && req1) ? ~last_owner : ~req0;
      end
    endcase

    other_req      = gp ? req0 : req1;
    state_nxt      = IDLE;
    count_nxt      = '0;
    last_owner_nxt = last_owner;
    if (gv) begin
      if (other_req && eff == MAX_CNT) begin
        state_nxt      = gp ? OWN0 : OWN1;
        count_nxt      = BCNT_W'(1);
        last_owner_nxt = gp;
      end else begin
        state_nxt = gp ? OWN1 : OWN0;
        count_nxt = (eff == MAX_CNT) ? MAX_CNT : eff + BCNT_W'(1);
      end
    end
    if (state == OWN0 && state_nxt != OWN0) last_owner_nxt = 1'b0;
    if (state == OWN1 && state_nxt != OWN1) last_owner_nxt = 1'b1;
  end

  // Grants are masked while reset is held so the SRAM is never touched.
  assign gnt0 = gv & ~gp & rst;
  assign gnt1 = gv & gp & rst;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      last_owner <= last_owner_nxt;
    end
  end

endmodule

// File: rtl/phy_mem_arbiter.sv
// Shares the single-port PHY buffer SRAM between the loader and the link side,
// driving the active-low SRAM controls and steering read data back.
module phy_mem_arbiter
  import phy_pkg::*;
#(
  parameter int AW        = PHY_AW,
  parameter int DW        = PHY_DW,
  parameter int MAX_BURST = PHY_MAX_BURST
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] rdata,
  output logic          csb0,
  output logic          web0,
  output logic [AW-1:0] addr0,
  output logic [DW-1:0] din0,
  input  logic [DW-1:0] dout0
);

  mem_req_t      m0, m1, sel;
  logic          beat;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic          rd_pending, rd_port;

  assign m0 = '{req: r0_req, we: r0_we, addr: r0_addr, wdata: r0_wdata};
  assign m1 = '{req: r1_req, we: r1_we, addr: r1_addr, wdata: r1_wdata};

  rr_burst_picker #(.MAX_BURST(MAX_BURST)) u_picker (
    .clk  (clk),
    .rst  (rst),
    .req0 (r0_req),
    .req1 (r1_req),
    .gnt0 (r0_gnt),
    .gnt1 (r1_gnt)
  );

  assign sel  = r1_gnt ? m1 : m0;
  assign beat = (r0_gnt | r1_gnt) & sel.req;

  // Address and write data hold their last values when idle to limit toggling.
  assign csb0  = ~beat;
  assign web0  = ~(beat & sel.we);
  assign addr0 = beat ? sel.addr : addr_q;
  assign din0  = (beat && sel.we) ? sel.wdata : din_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      din_q      <= '0;
      rd_pending <= 1'b0;
      rd_port    <= 1'b0;
    end else begin
      addr_q     <= addr0;
      din_q      <= din0;
      rd_pending <= beat & ~sel.we;
      rd_port    <= r1_gnt;
    end
  end

  assign r0_rvalid = rd_pending & ~rd_port;
  assign r1_rvalid = rd_pending & rd_port;
  assign rdata     = rd_pending ? dout0 : '0;

endmodule

// File: doc/phy_mem_arbiter.md
Name: phy_mem_arbiter

Overview:
- Shares the single-port 128x12 PHY buffer SRAM between two requesters.
  - Port 0: PHY loader side (frame load/unload).
  - Port 1: link/host side (command build, readback).
- Generates the active-low SRAM controls `csb0`/`web0`, plus `addr0` and `din0`.
- Round-robin ownership with a bounded burst length, so neither side starves.
- Returns read data to the owning requester one cycle after each read beat.

Parameters:
- AW, 7, SRAM address width
- DW, 12, SRAM data width
- MAX_BURST, 8, max consecutive beats one owner keeps while the other side waits (range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active low
- r0_req  in  1  port 0 requests a beat this cycle
- r0_we  in  1  port 0 beat is a write (1) or read (0)
- r0_addr  in  AW  port 0 address
- r0_wdata  in  DW  port 0 write data
- r0_gnt  out  1  port 0 beat accepted at this rising edge
- r0_rvalid  out  1  port 0 read data valid on rdata
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid: same as port 0
- rdata  out  DW  read data returned to the requester flagged by rX_rvalid
- csb0  out  1  SRAM chip select, active low
- web0  out  1  SRAM write enable, active low
- addr0  out  AW  SRAM address
- din0  out  DW  SRAM write data
- dout0  in  DW  SRAM read data, valid the cycle after a read beat

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE, beat count 0, last_owner=1 (port 0 wins first).
  - Outputs: r0_gnt/r1_gnt/r0_rvalid/r1_rvalid=0, csb0=1, web0=1, addr0=0, din0=0, rdata=0.
- States:
  - IDLE: no owner.
  - OWN0 / OWN1: port 0 / port 1 owns the SRAM.
- Grant timing:
  - rX_gnt, csb0, web0, addr0 and din0 are combinational from registered state, beat count and the current req inputs.
  - A beat completes at the rising edge where gnt=1.
  - Requesters hold req/we/addr/wdata stable until they see gnt.
- Ownership update each cycle (next-state):
  - IDLE, single req → that port. Both req → port != last_owner. No req → stay IDLE, csb0=1.
  - OWNx with rx_req=1, other port idle → stay in OWNx. Burst count saturates at MAX_BURST.
  - OWNx with rx_req=1, other port requesting, count < MAX_BURST → stay in OWNx, count++.
  - OWNx with rx_req=1, other port requesting, count == MAX_BURST → switch to the other port, count=1, last_owner=x. The current cycle's beat still goes to x.
  - OWNx with rx_req=0 → the other port's req is granted in this same cycle if asserted (zero-bubble handover), else IDLE. last_owner=x.
- Beat count: 1-based, counts beats granted to the current owner. A beat to a new owner sets it to 1.
- Read path:
  - A read beat (gnt=1, we=0) sets a registered rd_pending flag and rd_port.
  - Next cycle: rX_rvalid=1 for rd_port only, and rdata=dout0.
  - rvalid is one cycle wide. Back-to-back reads give back-to-back rvalid pulses.
  - A write beat never produces rvalid.
- Handover read: a read by port 0 followed immediately by port 1's beat still returns port 0's data, flagged by r0_rvalid in that cycle.
- Write beat: csb0=0, web0=0, din0=wdata.
- Read beat: csb0=0, web0=1, din0 holds its previous value.
- No beat: csb0=1, web0=1. addr0 and din0 hold their previous values (low toggle).
- Reset mid-burst: any in-flight rvalid is dropped. No SRAM access occurs while rst=0.
- Only one rX_gnt is ever high in a cycle. csb0=0 if and only if some gnt=1.

Decomposition:
- Shared package `phy_pkg`:
  - AW, DW, MAX_BURST defaults.
  - Typedef `arb_state_t` {IDLE, OWN0, OWN1}.
  - Typedef `mem_req_t` struct {req, we, addr, wdata}.
- One natural sub-module: `rr_burst_picker`, the grant/next-owner logic and beat counter. The top handles the SRAM mux and read-return pipeline.

Test Plan:
- Reset release, no reqs → csb0=1, web0=1, both gnt=0 and both rvalid=0 for 10 cycles.
- r0 writes addr 0x05=0xABC, then reads 0x05 → r0_gnt on both beats. Read beat: csb0=0, web0=1. Next cycle: r0_rvalid=1, rdata=0xABC, r1_rvalid=0.
- Both req continuously from IDLE, MAX_BURST=8 → port 0 gets 8 beats, then port 1 gets 8 beats, alternating. Never two gnt in one cycle.
- r0 reads addr 0x10 (=0x123) and drops req while r1 writes 0x11 → r1_gnt in the very next cycle. In that cycle r0_rvalid=1 with rdata=0x123.
- r1 alone for 20 beats → r1_gnt every cycle, count saturates, no stall. r0 then requests → r0 granted after at most 8 further r1 beats.
- rst asserted mid-burst right after a read beat → gnt and rvalid go to 0 immediately and csb0=1. After release, port 0 wins the first contended cycle.
